// File: rtl/except_pkg.sv
// Shared constants and types for the precise-exception / interrupt controller.
package except_pkg;

    // ExcCode values written into Cause[6:2]
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // CP0 register numbers
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Status bit positions
    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned IM_W     = 8;

    // Cause bit positions
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned EXC_W     = 5;
    localparam int unsigned CA_IP_LO  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: lowest asserted request index wins, pc/code muxed from it.
module exc_prio_enc
    import except_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned XLEN    = 32,
    localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]       exc_req,
    input  logic [NUM_SRC*XLEN-1:0]  exc_pc,
    input  logic [NUM_SRC*EXC_W-1:0] exc_code,
    output logic                     sel_valid_c,
    output logic [IDX_W-1:0]         sel_idx_c,
    output logic [XLEN-1:0]          sel_pc_c,
    output logic [EXC_W-1:0]         sel_code_c
);

    // Scan from the youngest source down so the oldest asserted one is left selected
    always_comb begin
        sel_valid_c = 1'b0;
        sel_idx_c   = '0;
        sel_pc_c    = '0;
        sel_code_c  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (exc_req[i]) begin
                sel_valid_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
                sel_pc_c    = exc_pc[i*XLEN +: XLEN];
                sel_code_c  = exc_code[i*EXC_W +: EXC_W];
            end
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Precise-exception and interrupt controller owning CP0 Status/Cause/EPC,
// issuing a registered flush/redirect and holding off events while the pipe drains.
module except_ctrl
    import except_pkg::*;
#(
    parameter int unsigned     NUM_SRC      = 4,
    parameter int unsigned     NIRQ         = 6,
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] VEC_ADDR     = 32'h0000_0080,
    parameter int unsigned     DRAIN_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       exc_req,
    input  logic [NUM_SRC*XLEN-1:0]  exc_pc,
    input  logic [NUM_SRC*5-1:0]     exc_code,
    input  logic [NIRQ-1:0]          irq,
    input  logic [XLEN-1:0]          irq_pc,
    input  logic                     eret,
    input  logic                     cp0_we,
    input  logic [4:0]               cp0_addr,
    input  logic [XLEN-1:0]          cp0_wdata,
    output logic [XLEN-1:0]          cp0_rdata,
    output logic                     flush,
    output logic                     redirect,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     busy,
    output logic [XLEN-1:0]          status,
    output logic [XLEN-1:0]          cause,
    output logic [XLEN-1:0]          epc
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    exc_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic              redirect_q, redirect_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   redirect_pc_q;

    logic              ie_q, exl_q;
    logic [IM_W-1:0]   im_q;
    logic [EXC_W-1:0]  exc_code_q;
    logic [NIRQ-1:0]   ip_q;
    logic [XLEN-1:0]   epc_q;

    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx_unused;
    logic [XLEN-1:0]   sel_pc;
    logic [EXC_W-1:0]  sel_code;

    logic              irq_pend;
    logic              take_exc, take_irq, take_eret;

    exc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .XLEN    (XLEN)
    ) u_prio (
        .exc_req     (exc_req),
        .exc_pc      (exc_pc),
        .exc_code    (exc_code),
        .sel_valid_c (sel_valid),
        .sel_idx_c   (sel_idx_unused),
        .sel_pc_c    (sel_pc),
        .sel_code_c  (sel_code)
    );

    // Interrupt is pending only when globally enabled and not already in exception level
    assign irq_pend = ie_q & ~exl_q & (|(ip_q & im_q[NIRQ-1:0]));

    // Next-state / event acceptance; events are only looked at in IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        redirect_d = 1'b0;
        take_exc   = 1'b0;
        take_irq   = 1'b0;
        take_eret  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    take_exc = 1'b1;
                end else if (irq_pend) begin
                    take_irq = 1'b1;
                end else if (eret) begin
                    take_eret = 1'b1;
                end
                if (take_exc || take_irq || take_eret) begin
                    state_d    = FLUSH;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d = DRAIN;
                cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state and registered pipeline-control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            busy_q        <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            busy_q     <= busy_d;
            if (take_exc || take_irq) begin
                redirect_pc_q <= VEC_ADDR;
            end else if (take_eret) begin
                redirect_pc_q <= epc_q;
            end
        end
    end

    // CP0 registers: an accepted event's updates take precedence over a software write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            exc_code_q <= '0;
            ip_q       <= '0;
            epc_q      <= '0;
        end else begin
            ip_q <= irq;
            if (take_exc) begin
                exc_code_q <= sel_code;
                exl_q      <= 1'b1;
                if (!exl_q) begin
                    epc_q <= sel_pc;
                end
            end else if (take_irq) begin
                exc_code_q <= EXC_INT;
                exl_q      <= 1'b1;
                epc_q      <= irq_pc;
            end else if (take_eret) begin
                exl_q <= 1'b0;
            end else if (cp0_we) begin
                if (cp0_addr == CP0_STATUS) begin
                    ie_q  <= cp0_wdata[ST_IE];
                    exl_q <= cp0_wdata[ST_EXL];
                    im_q  <= cp0_wdata[ST_IM_LO +: IM_W];
                end else if (cp0_addr == CP0_EPC) begin
                    epc_q <= cp0_wdata;
                end
            end
        end
    end

    // Architectural views of Status/Cause; unimplemented bits read 0
    always_comb begin
        status                   = '0;
        status[ST_IE]            = ie_q;
        status[ST_EXL]           = exl_q;
        status[ST_IM_LO +: IM_W] = im_q;
        cause                     = '0;
        cause[CA_EXC_LO +: EXC_W] = exc_code_q;
        cause[CA_IP_LO +: NIRQ]   = ip_q;
    end

    // CP0 read port, no write bypass
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_STATUS: cp0_rdata = status;
            CP0_CAUSE:  cp0_rdata = cause;
            CP0_EPC:    cp0_rdata = epc_q;
            default:    cp0_rdata = '0;
        endcase
    end

    assign epc         = epc_q;
    assign flush       = flush_q;
    assign redirect    = redirect_q;
    assign busy        = busy_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Parametrised precise-exception and interrupt controller. It replaces the combinational fault logic in the five-stage pipeline, which reports only cause and EPC. It accepts N prioritised synchronous exception sources plus maskable external interrupts and ERET, and owns the CP0 Status/Cause/EPC registers. It drives a registered flush/redirect to IF and the pipeline registers, then holds off new events while the flushed pipeline drains.

## Interface
- NUM_SRC, 4, number of synchronous exception sources; index 0 has the highest priority and is the oldest stage
- NIRQ, 6, external interrupt lines (1..8)
- XLEN, 32, datapath width
- VEC_ADDR, 32'h0000_0080, exception vector
- DRAIN_CYCLES, 3, cycles events are ignored after a flush (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- exc_req  in  NUM_SRC  per-source exception request, level-sampled each cycle
- exc_pc  in  NUM_SRC*XLEN  faulting PC per source, slice i = source i
- exc_code  in  NUM_SRC*5  ExcCode per source
- irq  in  NIRQ  external interrupts, level
- irq_pc  in  XLEN  PC of oldest uncommitted instruction (EPC for interrupts)
- eret  in  1  ERET in MEM this cycle
- cp0_we  in  1  CP0 write strobe
- cp0_addr  in  5  CP0 register number
- cp0_wdata  in  XLEN  write data
- cp0_rdata  out  XLEN  combinational read data
- flush  out  1  one-cycle pulse: kill IF_ID, ID_EX, EX_MEM contents
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  XLEN  target PC
- busy  out  1  high in FLUSH and DRAIN
- status, cause, epc  out  XLEN each  architectural register values

## Operation
- Status: bit0 IE, bit1 EXL, bits[15:8] IM; all other bits read 0.
- Cause: bits[6:2] ExcCode, bits[15:8] IP. IP[NIRQ-1:0] mirrors registered irq every cycle. Cause is read-only.
- EPC: full XLEN.
- CP0 map: 12 Status (writable bits only), 13 Cause, 14 EPC (writable); other addresses read 0 and ignore writes.
- Interrupt pending = IE & ~EXL & |(IP & IM).
- Event priority in IDLE: any exc_req, then pending interrupt, then eret.
- Exception: the lowest asserted index i is selected. Cause.ExcCode = exc_code[i]. EPC = exc_pc[i] only if EXL was 0; otherwise EPC is unchanged. EXL is set. redirect_pc = VEC_ADDR.
- Interrupt: ExcCode = 0, EPC = irq_pc, EXL is set, redirect_pc = VEC_ADDR.
- ERET: EXL is cleared and redirect_pc = EPC.
- FSM states:
  - IDLE: on an accepted event -> FLUSH.
  - FLUSH: lasts one cycle, then -> DRAIN with the counter loaded to DRAIN_CYCLES-1.
  - DRAIN: decrements the counter each cycle; -> IDLE after the cycle in which the counter is 0.
- exc_req, irq and eret are ignored in FLUSH and DRAIN. Sources must re-assert them if they are still valid.
- A CP0 write in the same cycle as an accepted event is dropped, because the event's register updates win. CP0 writes in FLUSH or DRAIN are honoured.
- Reset values: status, cause, epc, redirect_pc = 0; flush, redirect, busy = 0; FSM = IDLE; counter = 0. Reset mid-FLUSH or mid-DRAIN returns everything to these values at the next edge.

## Timing
- Event sampled at edge N. At N+1: flush = redirect = busy = 1, and redirect_pc, cause, epc, status show the new values.
- N+2 .. N+1+DRAIN_CYCLES: busy = 1, flush = redirect = 0.
- First cycle in which a new event is accepted: N+2+DRAIN_CYCLES.
- cp0_we at edge N updates the register at N+1. cp0_rdata returns the current register value combinationally, with no write bypass.
- IP lags irq by one cycle, so interrupt take-latency from irq assertion is 2 cycles.

## Structure
- Package except_pkg holds:
  - ExcCode constants: INT 0, SYS 8, BP 9, RI 10, OV 12
  - CP0 address constants: STATUS 12, CAUSE 13, EPC 14
  - Status/Cause bit positions
  - FSM state enum {IDLE, FLUSH, DRAIN}
- One sub-module, exc_prio_enc, combinational: a fixed-priority encoder over exc_req that outputs valid, the selected index, and the muxed pc and code.

## Test plan
- Reset, then read 12/13/14 -> all 0. flush, redirect and busy stay 0 for 10 cycles.
- exc_req = 4'b0110 with exc_pc[1] = 0x100, code[1] = 12 -> next cycle: flush/redirect = 1, redirect_pc = 0x80, EPC = 0x100, ExcCode = 12, EXL = 1. busy is high for 4 cycles.
- exc_req held high during DRAIN -> no second flush until cycle N+5. The second event keeps EPC = 0x100 (EXL = 1) and updates ExcCode.
- Write Status = 0x0000_0401 (IE, IM[2]), then irq[2] = 1 with irq_pc = 0x200 -> flush 2 cycles later, ExcCode = 0, EPC = 0x200. With EXL = 1 afterwards, irq is ignored.
- eret with EPC = 0x200 -> redirect_pc = 0x200, EXL = 0. Asserting eret together with exc_req[0] -> the exception is taken and EXL stays 1.
- Assert rst_n = 0 during DRAIN -> at the next edge busy = 0 and all registers = 0. An exc_req in the first cycle after reset is accepted.
